// File: rtl/dll_loopback_stub.sv
// dll_loopback_stub: stand-in for a PCIe data link layer.
// Brings the link up on a fixed timetable (linkup, then one VC at a time)
// and loops every accepted TX dword back to the RX side through a small
// first-word-fall-through FIFO.
module dll_loopback_stub #(
  parameter int LINKUP_DLY = 16,  // cycles from reset release to linkup (1..255)
  parameter int VC_UP_GAP  = 4,   // cycles between successive dll_vc_up bits (1..255)
  parameter int FIFO_DEPTH = 8    // loopback depth in dwords (power of 2, >= 2)
) (
  input  logic        tl_dll_clk,
  input  logic        arst,
  input  logic [31:0] tx_data_o,
  input  logic        tx_valid_o,
  output logic        tx_ready_i,
  input  logic [2:0]  vc_num,
  output logic [31:0] rx_data_i,
  output logic        rx_valid_i,
  input  logic        rx_ready_o,
  output logic        linkup,
  output logic [7:0]  dll_vc_up,
  output logic [15:0] dword_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] DLY_LAST = 8'(LINKUP_DLY - 1);
  localparam logic [7:0] GAP_LAST = 8'(VC_UP_GAP - 1);

  typedef enum logic [1:0] {
    ST_DOWN,
    ST_VC_INIT,
    ST_UP
  } link_state_e;

  link_state_e state;
  logic [7:0]  dly_cnt;
  logic [7:0]  gap_cnt;

  // Loopback storage; pointers carry one extra bit to tell full from empty.
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  // Link bring-up sequencer: DOWN counts to linkup, VC_INIT raises one VC
  // flag per gap, UP holds until the next reset.
  always_ff @(posedge tl_dll_clk or negedge arst) begin
    if (!arst) begin
      state     <= ST_DOWN;
      dly_cnt   <= '0;
      gap_cnt   <= '0;
      linkup    <= 1'b0;
      dll_vc_up <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      case (state)
        ST_DOWN: begin
          if (dly_cnt == DLY_LAST) begin
            linkup  <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_VC_INIT;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end
        ST_VC_INIT: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt   <= '0;
            dll_vc_up <= {dll_vc_up[6:0], 1'b1};
            // Bit 6 already set means this step completes 8'hFF.
            if (dll_vc_up[6]) state <= ST_UP;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_UP:   state <= ST_UP;
        default: state <= ST_DOWN;
      endcase
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A dword is only accepted on an initialised VC with room in the FIFO.
  assign tx_ready_i = linkup & dll_vc_up[vc_num] & ~fifo_full;
  assign push       = tx_valid_o & tx_ready_i;

  // FWFT head; forced to zero while empty so reset shows a clean bus.
  assign rx_valid_i = ~fifo_empty;
  assign rx_data_i  = fifo_empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign pop        = rx_valid_i & rx_ready_o;

  // FIFO data array write port.
  // NOTE: the data array has no reset; emptiness comes from the pointers,
  // which keeps the storage a plain RAM.
  always_ff @(posedge tl_dll_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data_o;
  end

  // FIFO pointers and accepted-dword counter.
  always_ff @(posedge tl_dll_clk or negedge arst) begin
    if (!arst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dword_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        dword_cnt <= dword_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_dll_loopback_stub.sv
// Testbench for dll_loopback_stub: directed bring-up / gating / loopback /
// full / reset / wrap sequences plus random traffic, all compared against a
// queue-based reference model evaluated every cycle.
module tb_dll_loopback_stub;

  localparam int LINKUP_DLY = 16;
  localparam int VC_UP_GAP  = 4;
  localparam int FIFO_DEPTH = 8;

  logic        tl_dll_clk = 1'b0;
  logic        arst       = 1'b0;
  logic [31:0] tx_data_o  = '0;
  logic        tx_valid_o = 1'b0;
  logic        tx_ready_i;
  logic [2:0]  vc_num     = '0;
  logic [31:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o = 1'b0;
  logic        linkup;
  logic [7:0]  dll_vc_up;
  logic [15:0] dword_cnt;

  dll_loopback_stub #(
    .LINKUP_DLY(LINKUP_DLY),
    .VC_UP_GAP (VC_UP_GAP),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .tl_dll_clk(tl_dll_clk),
    .arst      (arst),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .vc_num    (vc_num),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .linkup    (linkup),
    .dll_vc_up (dll_vc_up),
    .dword_cnt (dword_cnt)
  );

  always #5 tl_dll_clk = ~tl_dll_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc   = 0;   // rising edges since reset release
  logic [15:0] m_cnt = '0;
  logic [31:0] q[$];

  function automatic logic m_linkup();
    return cyc >= LINKUP_DLY;
  endfunction

  function automatic logic [7:0] m_vc_up();
    int n;
    logic [8:0] v;
    if (cyc < LINKUP_DLY) return 8'h00;
    n = (cyc - LINKUP_DLY) / VC_UP_GAP;
    if (n > 8) n = 8;
    v = (9'd1 << n) - 9'd1;
    return v[7:0];
  endfunction

  function automatic logic m_ready();
    logic [7:0] v;
    v = m_vc_up();
    return m_linkup() && v[vc_num] && (q.size() < FIFO_DEPTH);
  endfunction

  // Compare every output with the model, then advance model and DUT one edge.
  task automatic tick();
    logic        exp_ready;
    logic        do_push;
    logic        do_pop;
    #1;
    exp_ready = m_ready();
    check($sformatf("tx_ready@%0d", cyc), {31'd0, tx_ready_i}, {31'd0, exp_ready});
    check($sformatf("rx_valid@%0d", cyc), {31'd0, rx_valid_i}, {31'd0, q.size() > 0});
    check($sformatf("rx_data@%0d", cyc), rx_data_i, (q.size() > 0) ? q[0] : 32'h0);
    check($sformatf("linkup@%0d", cyc), {31'd0, linkup}, {31'd0, m_linkup()});
    check($sformatf("vc_up@%0d", cyc), {24'd0, dll_vc_up}, {24'd0, m_vc_up()});
    check($sformatf("dword_cnt@%0d", cyc), {16'd0, dword_cnt}, {16'd0, m_cnt});
    do_push = tx_valid_o && exp_ready;
    do_pop  = (q.size() > 0) && rx_ready_o;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(tx_data_o);
      m_cnt = m_cnt + 16'd1;
    end
    cyc++;
    @(posedge tl_dll_clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release off-edge.
  task automatic do_reset(input string tag);
    arst = 1'b0;
    #1;
    check({tag, "_rx_valid"}, {31'd0, rx_valid_i}, 32'd0);
    check({tag, "_rx_data"},  rx_data_i, 32'h0);
    check({tag, "_linkup"},   {31'd0, linkup}, 32'd0);
    check({tag, "_vc_up"},    {24'd0, dll_vc_up}, 32'h0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready_i}, 32'd0);
    check({tag, "_dword_cnt"}, {16'd0, dword_cnt}, 32'h0);
    q.delete();
    cyc   = 0;
    m_cnt = '0;
    @(posedge tl_dll_clk);
    @(posedge tl_dll_clk);
    #2;
    arst = 1'b1;
  endtask

  task automatic idle_inputs();
    tx_valid_o = 1'b0;
    rx_ready_o = 1'b0;
    vc_num     = 3'd0;
    tx_data_o  = '0;
  endtask

  // ---------------- table-driven loopback ----------------
  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        rx_rdy;
    logic        exp_ready;
    logic        exp_rx_valid;
    logic [31:0] exp_rx_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // FIFO empty, dword_cnt = 1 when this table starts; rx_ready held high.
    tbl[0] = '{1'b1, 32'hDEAD0001, 1'b1, 1'b1, 1'b0, 32'h0,        16'd1};
    tbl[1] = '{1'b1, 32'hDEAD0002, 1'b1, 1'b1, 1'b1, 32'hDEAD0001, 16'd2};
    tbl[2] = '{1'b1, 32'hDEAD0003, 1'b1, 1'b1, 1'b1, 32'hDEAD0002, 16'd3};
    tbl[3] = '{1'b1, 32'hDEAD0004, 1'b1, 1'b1, 1'b1, 32'hDEAD0003, 16'd4};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEAD0004, 16'd5};
    tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        16'd5};

    // --- reset state and bring-up with a gated VC 3 request pending ---
    idle_inputs();
    do_reset("rst0");
    vc_num     = 3'd3;
    tx_valid_o = 1'b1;
    tx_data_o  = 32'hDEADBEEF;
    while (cyc < 15) tick();
    check("linkup_before_dly", {31'd0, linkup}, 32'd0);
    tick();
    check("linkup_at_dly", {31'd0, linkup}, 32'd1);
    while (cyc < 28) tick();
    check("gate_vc_up_07", {24'd0, dll_vc_up}, 32'h07);
    check("gate_tx_ready", {31'd0, tx_ready_i}, 32'd0);
    check("gate_cnt", {16'd0, dword_cnt}, 32'd0);
    while (cyc < 33) tick();
    check("gate_accepted_cnt", {16'd0, dword_cnt}, 32'd1);
    check("gate_rx_data", rx_data_i, 32'hDEADBEEF);
    tx_valid_o = 1'b0;
    while (cyc < 44) tick();
    check("vc_up_7f", {24'd0, dll_vc_up}, 32'h7F);
    while (cyc < 48) tick();
    check("vc_up_ff", {24'd0, dll_vc_up}, 32'hFF);
    rx_ready_o = 1'b1;
    tick();
    tick();

    // --- loopback table ---
    vc_num = 3'd0;
    for (int i = 0; i < 6; i++) begin
      tx_valid_o = tbl[i].valid;
      tx_data_o  = tbl[i].data;
      rx_ready_o = tbl[i].rx_rdy;
      #1;
      check($sformatf("tbl%0d_tx_ready", i), {31'd0, tx_ready_i}, {31'd0, tbl[i].exp_ready});
      check($sformatf("tbl%0d_rx_valid", i), {31'd0, rx_valid_i}, {31'd0, tbl[i].exp_rx_valid});
      check($sformatf("tbl%0d_rx_data", i), rx_data_i, tbl[i].exp_rx_data);
      check($sformatf("tbl%0d_cnt", i), {16'd0, dword_cnt}, {16'd0, tbl[i].exp_cnt});
      tick();
    end

    // --- backpressure until full, then simultaneous pop / delayed push ---
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      tx_data_o = 32'hB0B0_0000 + 32'(i);
      tick();
    end
    tx_data_o = 32'hB0B0_0100;
    #1;
    check("full_tx_ready", {31'd0, tx_ready_i}, 32'd0);
    check("full_head", rx_data_i, 32'hB0B0_0000);
    rx_ready_o = 1'b1;
    tick();
    check("after_pop_tx_ready", {31'd0, tx_ready_i}, 32'd1);
    check("after_pop_head", rx_data_i, 32'hB0B0_0001);
    tick();
    tx_valid_o = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) tick();

    // --- random traffic on a fully-up link ---
    for (int i = 0; i < 400; i++) begin
      tx_valid_o = ($urandom_range(0, 3) != 0);
      tx_data_o  = $urandom;
      vc_num     = 3'($urandom_range(0, 7));
      rx_ready_o = ($urandom_range(0, 2) == 0);
      tick();
    end
    tx_valid_o = 1'b0;
    rx_ready_o = 1'b1;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) tick();

    // --- reset with 5 dwords buffered ---
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b1;
    vc_num     = 3'd5;
    for (int i = 0; i < 5; i++) begin
      tx_data_o = 32'h5A5A_0000 + 32'(i);
      tick();
    end
    check("pre_reset_rx_valid", {31'd0, rx_valid_i}, 32'd1);
    idle_inputs();
    do_reset("rst1");
    while (cyc < 48) tick();
    check("rebringup_vc_ff", {24'd0, dll_vc_up}, 32'hFF);

    // --- dword_cnt wrap: 65537 accepted dwords from zero ---
    tx_valid_o = 1'b1;
    rx_ready_o = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      tx_data_o = 32'(i);
      tick();
    end
    tx_valid_o = 1'b0;
    tick();
    check("cnt_wrap", {16'd0, dword_cnt}, 32'h0001);

    // --- random traffic through a fresh bring-up (exercises VC gating) ---
    idle_inputs();
    do_reset("rst2");
    for (int i = 0; i < 300; i++) begin
      tx_valid_o = ($urandom_range(0, 1) != 0);
      tx_data_o  = $urandom;
      vc_num     = 3'($urandom_range(0, 7));
      rx_ready_o = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
